bch_error_injector: RTL and testbench



---
 rtl/bch_pkg.sv | 20 ++
 rtl/lfsr16.sv | 24 ++
 rtl/bch_error_injector.sv | 113 +++++++++++
 tb/tb_bch_error_injector.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bch_pkg.sv
// Shared definitions for the BCH(15,7) transmission pipeline: code sizes,
// LFSR feedback polynomial and the error-injector state encoding.
package bch_pkg;

   localparam int BCH_N = 15;
   localparam int BCH_K = 7;
   localparam int BCH_T = 2;

   // Galois right-shift feedback for x^16 + x^14 + x^13 + x^11 + 1
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      INJECT = 2'd1,
      OUT    = 2'd2
   } inj_state_t;

   typedef logic [BCH_N-1:0] codeword_t;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; a zero seed is replaced by 1 so the
// register can never lock up in the all-zero state.
module lfsr16
   import bch_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [15:0] value
);

   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

   always_ff @(posedge clk) begin
      if (rst) begin
         value <= SEED_EFF;
      end else if (en) begin
         value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0000);
      end
   end

endmodule

// File: rtl/bch_error_injector.sv
// Channel-impairment stage: flips a caller mask or a number of distinct
// LFSR-chosen bit positions in each accepted codeword.
module bch_error_injector
   import bch_pkg::*;
#(
   parameter int          N    = 15,
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [N-1:0] s_data,
   input  logic         random_en,
   input  logic [7:0]   num_errors,
   input  logic [N-1:0] err_mask_in,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [N-1:0] m_data,
   output logic [N-1:0] err_mask,
   output logic         busy
);

   localparam int         POS_W = $clog2(N);
   localparam logic [7:0] N_CNT = 8'(N);

   inj_state_t       state, state_next;
   logic [N-1:0]     data_q, data_next;
   logic [N-1:0]     mask_q, mask_next;
   logic [N-1:0]     cand;
   logic [7:0]       remaining, remaining_next;
   logic [15:0]      lfsr;
   logic [POS_W-1:0] pos;
   logic             unused_lfsr;

   lfsr16 #(.SEED(SEED)) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .en    (1'b1),
      .value (lfsr)
   );

   assign pos         = lfsr[POS_W-1:0];
   assign unused_lfsr = ^lfsr[15:POS_W];

   // One-hot candidate; a position >= N shifts the bit out and yields zero,
   // which rejects it without any compare or modulo.
   assign cand = {{(N-1){1'b0}}, 1'b1} << pos;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         data_q    <= '0;
         mask_q    <= '0;
         remaining <= '0;
      end else begin
         state     <= state_next;
         data_q    <= data_next;
         mask_q    <= mask_next;
         remaining <= remaining_next;
      end
   end

   always_comb begin
      state_next     = state;
      data_next      = data_q;
      mask_next      = mask_q;
      remaining_next = remaining;
      s_ready        = 1'b0;
      m_valid        = 1'b0;
      busy           = 1'b1;
      case (state)
         IDLE: begin
            s_ready = 1'b1;
            busy    = 1'b0;
            if (s_valid) begin
               data_next      = s_data;
               remaining_next = (num_errors > N_CNT) ? N_CNT : num_errors;
               if (!random_en) begin
                  mask_next  = err_mask_in;
                  state_next = OUT;
               end else begin
                  mask_next  = '0;
                  state_next = (remaining_next == 8'd0) ? OUT : INJECT;
               end
            end
         end
         INJECT: begin
            if ((cand != '0) && ((mask_q & cand) == '0)) begin
               mask_next      = mask_q | cand;
               remaining_next = remaining - 8'd1;
               if (remaining == 8'd1) begin
                  state_next = OUT;
               end
            end
         end
         OUT: begin
            m_valid = 1'b1;
            if (m_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Both terms are registers, so the outputs stay put while OUT waits.
   assign m_data   = data_q ^ mask_q;
   assign err_mask = mask_q;

endmodule

// File: tb/tb_bch_error_injector.sv
// Directed bench for bch_error_injector with a rejection-sampling reference
// model checked every cycle, plus hand-computed literal expectations.
module tb_bch_error_injector;

   localparam int          N    = 15;
   localparam logic [15:0] SEED = 16'hACE1;
   localparam logic [15:0] TAPS = 16'hB400;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic [N-1:0] s_data = '0;
   logic         random_en = 1'b0;
   logic [7:0]   num_errors = '0;
   logic [N-1:0] err_mask_in = '0;
   logic         m_valid;
   logic         m_ready = 1'b1;
   logic [N-1:0] m_data;
   logic [N-1:0] err_mask;
   logic         busy;

   int n_cmp = 0;
   int n_bad = 0;

   bch_error_injector #(.N(N), .SEED(SEED)) dut (
      .clk         (clk),
      .rst         (rst),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .random_en   (random_en),
      .num_errors  (num_errors),
      .err_mask_in (err_mask_in),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .err_mask    (err_mask),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return (l >> 1) ^ (l[0] ? TAPS : 16'h0000);
   endfunction

   // Draw positions from the LFSR sequence after l0, skipping out-of-range
   // and repeated ones, until k distinct bits are set.
   function automatic void plan(input logic [15:0] l0, input int k,
                                output logic [N-1:0] msk, output int tries);
      logic [15:0] l;
      int          got;
      int          p;
      l     = l0;
      got   = 0;
      msk   = '0;
      tries = 0;
      while (got < k) begin
         l = lfsr_step(l);
         tries++;
         p = int'(l[3:0]);
         if (p < N && !msk[p]) begin
            msk[p] = 1'b1;
            got++;
         end
      end
   endfunction

   int           ph = 0;            // 0 idle, 1 injecting, 2 output pending
   int           wait_cnt = 0;
   logic [15:0]  mlfsr = '0;
   logic [N-1:0] exp_data = '0;
   logic [N-1:0] exp_mask = '0;
   bit           model_live = 1'b0;

   always @(posedge clk) begin : model
      logic [N-1:0] msk;
      int           t;
      int           k;
      if (rst) begin
         ph         <= 0;
         mlfsr      <= SEED;
         exp_data   <= '0;
         exp_mask   <= '0;
         model_live <= 1'b1;
      end else begin
         case (ph)
            0: if (s_valid) begin
               if (!random_en) begin
                  msk = err_mask_in;
                  t   = 0;
               end else begin
                  k = (int'(num_errors) > N) ? N : int'(num_errors);
                  plan(mlfsr, k, msk, t);
               end
               exp_mask <= msk;
               exp_data <= s_data ^ msk;
               wait_cnt <= t;
               ph       <= (t == 0) ? 2 : 1;
            end
            1: begin
               wait_cnt <= wait_cnt - 1;
               if (wait_cnt == 1) ph <= 2;
            end
            default: if (m_ready) ph <= 0;
         endcase
         mlfsr <= lfsr_step(mlfsr);
      end
   end

   always @(negedge clk) begin
      if (model_live) begin
         check("s_ready", 32'(s_ready), 32'(ph == 0));
         check("busy", 32'(busy), 32'(ph != 0));
         check("m_valid", 32'(m_valid), 32'(ph == 2));
         if (ph == 2) begin
            check("m_data", 32'(m_data), 32'(exp_data));
            check("err_mask", 32'(err_mask), 32'(exp_mask));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic send_frame(input logic [N-1:0] d, input logic rnd, input logic [7:0] num,
                             input logic [N-1:0] mi, input int hold,
                             output logic [N-1:0] got_data, output logic [N-1:0] got_mask,
                             output int lat);
      s_data      = d;
      random_en   = rnd;
      num_errors  = num;
      err_mask_in = mi;
      s_valid     = 1'b1;
      m_ready     = (hold == 0);
      @(posedge clk); #1;
      s_valid = 1'b0;
      lat     = 1;
      while (!m_valid && lat < 2000) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!m_valid) begin
         check("m_valid_timeout", 32'(m_valid), 32'd1);
      end
      got_data = m_data;
      got_mask = err_mask;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_m_valid", 32'(m_valid), 32'd1);
         check("hold_s_ready", 32'(s_ready), 32'd0);
      end
      m_ready = 1'b1;
      @(posedge clk); #1;
      check("idle_after_hs", 32'(s_ready), 32'd1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [N-1:0] gd;
      logic [N-1:0] gm;
      logic [N-1:0] d;
      int           lat;

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_s_ready", 32'(s_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_err_mask", 32'(err_mask), 32'd0);
      check("rst_lfsr", 32'(dut.lfsr), 32'hACE1);

      // deterministic mask, one-cycle latency
      send_frame(15'h7FFF, 1'b0, 8'd0, 15'h0011, 0, gd, gm, lat);
      check("det_data", 32'(gd), 32'h7FEE);
      check("det_mask", 32'(gm), 32'h0011);
      check("det_lat", 32'(lat), 32'd1);

      // random with zero errors
      send_frame(15'h1234, 1'b1, 8'd0, 15'h7FFF, 0, gd, gm, lat);
      check("zero_data", 32'(gd), 32'h1234);
      check("zero_mask", 32'(gm), 32'h0000);
      check("zero_lat", 32'(lat), 32'd1);

      // many random frames with three errors each
      for (int f = 0; f < 200; f++) begin
         d = N'($urandom_range(0, 32767));
         send_frame(d, 1'b1, 8'd3, N'($urandom_range(0, 32767)), 0, gd, gm, lat);
         check("rand3_popcount", 32'($countones(gm)), 32'd3);
         check("rand3_lat_ge4", 32'(lat >= 4), 32'd1);
      end

      // saturation: every bit flips
      send_frame(15'h0F0F, 1'b1, 8'd20, 15'h0000, 0, gd, gm, lat);
      check("sat_mask", 32'(gm), 32'h7FFF);
      check("sat_data", 32'(gd), 32'h70F0);

      // back-pressure held for five cycles in OUT
      send_frame(15'h2AAA, 1'b0, 8'd0, 15'h4001, 5, gd, gm, lat);
      check("bp_data", 32'(gd), 32'h6AAB);
      check("bp_mask", 32'(gm), 32'h4001);
      check("bp_busy_after", 32'(busy), 32'd0);

      // first random frame after reset: candidates 0 then 8 from ACE1
      do_reset();
      send_frame(15'h0000, 1'b1, 8'd2, 15'h0000, 0, gd, gm, lat);
      check("first_mask", 32'(gm), 32'h0101);
      check("first_lat", 32'(lat), 32'd3);

      // reset in the middle of INJECT
      s_data     = 15'h5555;
      random_en  = 1'b1;
      num_errors = 8'd2;
      s_valid    = 1'b1;
      @(posedge clk); #1;
      s_valid = 1'b0;
      check("mid_busy_before", 32'(busy), 32'd1);
      do_reset();
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_m_valid", 32'(m_valid), 32'd0);
      check("mid_s_ready", 32'(s_ready), 32'd1);
      check("mid_err_mask", 32'(err_mask), 32'd0);
      check("mid_lfsr", 32'(dut.lfsr), 32'hACE1);
      send_frame(15'h0000, 1'b1, 8'd2, 15'h0000, 0, gd, gm, lat);
      check("after_mid_mask", 32'(gm), 32'h0101);
      check("after_mid_lat", 32'(lat), 32'd3);

      repeat (3) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      n_cmp++;
      n_bad++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
